// File: rtl/freelist_mw.sv
// freelist_mw: multi-way physical-register free list for the rename stage.
// Circular buffer of free tags with wrap-bit pointers. Up to WAYS tags are
// granted per cycle (combinationally), up to WAYS tags are returned per
// cycle from retire, and the head pointer can be restored on recovery.
// Optional build macro: FREELIST_BYPASS_EN lets requests that exceed the
// stored free count be served directly from this cycle's retire lanes.
module freelist_mw #(
    parameter int PR_W       = 6,
    parameter int DEPTH      = 32,
    parameter int WAYS       = 3,
    parameter int FIRST_FREE = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WAYS-1:0]           dispatch_req,
    input  logic [WAYS-1:0]           retire_en,
    input  logic [WAYS*PR_W-1:0]      retire_reg,
    input  logic                      recover_en,
    input  logic [$clog2(DEPTH):0]    recover_head,
    output logic [WAYS*PR_W-1:0]      free_reg,
    output logic [WAYS-1:0]           free_valid,
    output logic [$clog2(DEPTH):0]    head,
    output logic [$clog2(DEPTH):0]    free_count,
    output logic                      overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    // One extra bit so count + lane arithmetic never wraps before comparison.
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [PR_W-1:0]        mem_r [DEPTH];
    logic                   overflow_r;

    logic [PTR_W-1:0]       count_s;
    logic [CW-1:0]          count_w_s;
    logic [WAYS-1:0]        grant_v_s;
    logic [WAYS*PR_W-1:0]   grant_reg_s;
    logic [CW-1:0]          n_stored_s;
    logic [CW-1:0]          n_byp_s;
    logic [WAYS*PR_W-1:0]   ret_c_s;
    logic [CW-1:0]          ret_n_s;
    logic [WAYS-1:0]        wr_en_s;
    logic [WAYS*IDX_W-1:0]  wr_idx_s;
    logic [WAYS*PR_W-1:0]   wr_data_s;
    logic [CW-1:0]          n_acc_s;
    logic                   drop_s;

    // Wrap bits make tail - head unambiguous for both empty (0) and full (DEPTH).
    assign count_s   = tail_r - head_r;
    assign count_w_s = {1'b0, count_s};

    assign free_valid   = grant_v_s;
    assign free_reg     = grant_reg_s;
    assign head         = head_r;
    assign free_count   = count_s;
    assign overflow_err = overflow_r;

    // Compact enabled retire lanes into ascending order so they fill consecutive slots.
    always_comb begin : retire_compact
        ret_c_s = '0;
        ret_n_s = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (retire_en[i]) begin
                ret_c_s[int'(ret_n_s)*PR_W +: PR_W] = retire_reg[i*PR_W +: PR_W];
                ret_n_s = ret_n_s + CW'(1);
            end else begin
                ret_n_s = ret_n_s;
            end
        end
    end

    // Rank requesting lanes and grant stored tags while the registered count allows.
    always_comb begin : grant_logic
        logic [CW-1:0]    k;
        logic [PTR_W-1:0] rd_ptr;
        grant_v_s   = '0;
        grant_reg_s = '0;
        n_stored_s  = '0;
        n_byp_s     = '0;
        k           = '0;
        rd_ptr      = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (dispatch_req[i] && !recover_en && reset_n) begin
                if (k < count_w_s) begin
                    rd_ptr = head_r + PTR_W'(k);
                    grant_v_s[i] = 1'b1;
                    grant_reg_s[i*PR_W +: PR_W] = mem_r[rd_ptr[IDX_W-1:0]];
                    n_stored_s = n_stored_s + CW'(1);
                end
`ifdef FREELIST_BYPASS_EN
                else if ((k - count_w_s) < ret_n_s) begin
                    grant_v_s[i] = 1'b1;
                    grant_reg_s[i*PR_W +: PR_W] = ret_c_s[int'(k - count_w_s)*PR_W +: PR_W];
                    n_byp_s = n_byp_s + CW'(1);
                end
`endif
                else begin
                    grant_v_s[i] = 1'b0;
                end
                k = k + CW'(1);
            end else begin
                k = k;
            end
        end
    end

    // Accept retires into the array while capacity remains; bypassed tags are skipped.
    always_comb begin : retire_accept
        logic [CW-1:0]    base;
        logic [CW-1:0]    acc;
        logic [PTR_W-1:0] wr_ptr;
        wr_en_s   = '0;
        wr_idx_s  = '0;
        wr_data_s = '0;
        drop_s    = 1'b0;
        acc       = '0;
        wr_ptr    = '0;
        if (recover_en) begin
            base = {1'b0, PTR_W'(tail_r - recover_head)};
        end else begin
            base = count_w_s - n_stored_s;
        end
        for (int j = 0; j < WAYS; j++) begin
            if ((CW'(j) < ret_n_s) && (CW'(j) >= n_byp_s)) begin
                if ((base + acc) < DEPTH_C) begin
                    wr_ptr = tail_r + PTR_W'(acc);
                    wr_en_s[j] = 1'b1;
                    wr_idx_s[j*IDX_W +: IDX_W] = wr_ptr[IDX_W-1:0];
                    wr_data_s[j*PR_W +: PR_W]  = ret_c_s[j*PR_W +: PR_W];
                    acc = acc + CW'(1);
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                acc = acc;
            end
        end
        n_acc_s = acc;
    end

    // Pointer, array and sticky-error state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r     <= '0;
            tail_r     <= PTR_W'(DEPTH);
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= PR_W'(FIRST_FREE + i);
            end
        end else begin
            if (recover_en) begin
                head_r <= recover_head;
            end else begin
                head_r <= head_r + PTR_W'(n_stored_s);
            end
            tail_r <= tail_r + PTR_W'(n_acc_s);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            for (int j = 0; j < WAYS; j++) begin
                if (wr_en_s[j]) begin
                    mem_r[wr_idx_s[j*IDX_W +: IDX_W]] <= wr_data_s[j*PR_W +: PR_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_freelist_mw.sv
// tb_freelist_mw: directed test-plan checks plus randomized traffic compared
// every cycle against an unbounded-counter model of the free list.
module tb_freelist_mw;

    localparam int W  = 3;
    localparam int PW = 6;
    localparam int D  = 32;

    logic            clock;
    logic            reset_n;
    logic [W-1:0]    dispatch_req;
    logic [W-1:0]    retire_en;
    logic [W*PW-1:0] retire_reg;
    logic            recover_en;
    logic [5:0]      recover_head;
    logic [W*PW-1:0] free_reg;
    logic [W-1:0]    free_valid;
    logic [5:0]      head;
    logic [5:0]      free_count;
    logic            overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: head/tail as ever-increasing counts of tags taken/returned.
    int         mh;
    int         mt;
    logic [5:0] mm [D];
    bit         mov;

    freelist_mw #(.PR_W(PW), .DEPTH(D), .WAYS(W), .FIRST_FREE(32)) dut (
        .clock(clock), .reset_n(reset_n), .dispatch_req(dispatch_req),
        .retire_en(retire_en), .retire_reg(retire_reg), .recover_en(recover_en),
        .recover_head(recover_head), .free_reg(free_reg), .free_valid(free_valid),
        .head(head), .free_count(free_count), .overflow_err(overflow_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update and comparison, once per cycle between active edges.
    always @(negedge clock) begin : model_cmp
        int cnt, k, base, acc, newh, c;
        logic [W-1:0]    ev;
        logic [W*PW-1:0] er;
        if (!reset_n) begin
            mh = 0; mt = D; mov = 0;
            for (int i = 0; i < D; i++) mm[i] = 6'(32 + i);
        end else begin
            cnt = mt - mh;
            k = 0; ev = '0; er = '0;
            for (int i = 0; i < W; i++) begin
                if (dispatch_req[i] && !recover_en) begin
                    if (k < cnt) begin
                        ev[i] = 1'b1;
                        er[i*PW +: PW] = mm[(mh + k) % D];
                    end
                    k++;
                end
            end
            chk("m_head", 32'(head), 32'(mh % 64));
            chk("m_count", 32'(free_count), 32'(cnt));
            chk("m_ovf", 32'(overflow_err), 32'(mov));
            chk("m_valid", 32'(free_valid), 32'(ev));
            chk("m_reg", 32'(free_reg), 32'(er));
            if (recover_en) begin
                c    = ((mt % 64) - int'(recover_head) + 64) % 64;
                base = c;
                newh = mt - c;
            end else begin
                base = cnt - $countones(ev);
                newh = mh + $countones(ev);
            end
            acc = 0;
            for (int j = 0; j < W; j++) begin
                if (retire_en[j]) begin
                    if (base + acc < D) begin
                        mm[(mt + acc) % D] = retire_reg[j*PW +: PW];
                        acc++;
                    end else begin
                        mov = 1;
                    end
                end
            end
            mt = mt + acc;
            mh = newh;
        end
    end

    task automatic drive(input logic [W-1:0] req, input logic [W-1:0] ren,
                         input logic [W*PW-1:0] rreg, input logic rec, input logic [5:0] rh);
        @(posedge clock);
        #1;
        dispatch_req = req; retire_en = ren; retire_reg = rreg;
        recover_en = rec; recover_head = rh;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        dispatch_req = 3'b111; retire_en = '0; retire_reg = '0; recover_en = 1'b0; recover_head = '0;
        #1;
        chk("rst_valid", 32'(free_valid), 32'd0);
        chk("rst_reg", 32'(free_reg), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #1;
        dispatch_req = '0;
        reset_n = 1'b1;
        #1;
        chk("rst_head", 32'(head), 32'd0);
        chk("rst_count", 32'(free_count), 32'd32);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
    endtask

    int         q[$];
    int         tagc;
    logic [5:0] exp_tag;
    int         c;

    initial begin
        reset_n = 1'b0;
        dispatch_req = '0; retire_en = '0; retire_reg = '0; recover_en = 1'b0; recover_head = '0;
        do_reset();

        // First grant after reset.
        drive(3'b111, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("g1_reg", 32'(free_reg), 32'({6'd34, 6'd33, 6'd32}));
        chk("g1_valid", 32'(free_valid), 32'd7);
        drive(3'b000, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("g1_head", 32'(head), 32'd3);
        chk("g1_count", 32'(free_count), 32'd29);

        // Drain the full list three at a time.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(3'b111, 3'b000, '0, 1'b0, 6'd0);
            #1;
            if (i == 10) begin
                chk("drain_valid", 32'(free_valid), 32'd3);
                chk("drain_count", 32'(free_count), 32'd2);
                chk("drain_reg", 32'(free_reg), 32'({6'd0, 6'd63, 6'd62}));
            end
        end
        drive(3'b111, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("empty_count", 32'(free_count), 32'd0);
        chk("empty_valid", 32'(free_valid), 32'd0);

        // Retire into an empty list: no same-cycle grant, grantable next cycle.
        drive(3'b001, 3'b101, {6'd40, 6'd0, 6'd41}, 1'b0, 6'd0);
        #1;
        chk("ret_nogrant", 32'(free_valid), 32'd0);
        drive(3'b001, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("ret_grant_v", 32'(free_valid), 32'd1);
        chk("ret_grant_reg", 32'(free_reg), 32'd41);
        chk("ret_count2", 32'(free_count), 32'd2);
        drive(3'b000, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("ret_count1", 32'(free_count), 32'd1);

        // Overflow when retiring into a full list; sticky until reset.
        do_reset();
        drive(3'b000, 3'b001, 18'd5, 1'b0, 6'd0);
        drive(3'b000, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(free_count), 32'd32);
        drive(3'b111, 3'b000, '0, 1'b0, 6'd0);
        drive(3'b000, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // Recovery back to head=2.
        do_reset();
        drive(3'b111, 3'b000, '0, 1'b0, 6'd0);
        drive(3'b011, 3'b000, '0, 1'b0, 6'd0);
        drive(3'b111, 3'b000, '0, 1'b1, 6'd2);
        #1;
        chk("rec_head5", 32'(head), 32'd5);
        chk("rec_valid", 32'(free_valid), 32'd0);
        drive(3'b001, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("rec_head2", 32'(head), 32'd2);
        chk("rec_count", 32'(free_count), 32'd30);
        chk("rec_reg", 32'(free_reg), 32'd34);

        // Wrap: steady three-in/three-out traffic, FIFO order tracked in a queue.
        do_reset();
        q.delete();
        for (int i = 0; i < D; i++) q.push_back(32 + i);
        tagc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            drive(3'b111, 3'b111, {6'(tagc + 2), 6'(tagc + 1), 6'(tagc)}, 1'b0, 6'd0);
            #1;
            if (cyc == 11) chk("wrap_head33", 32'(head), 32'd33);
            chk("wrap_count", 32'(free_count), 32'd32);
            for (int l = 0; l < W; l++) begin
                exp_tag = 6'(q.pop_front());
                chk("wrap_fifo", 32'(free_reg[l*PW +: PW]), 32'(exp_tag));
            end
            for (int l = 0; l < W; l++) q.push_back(tagc + l);
            tagc = (tagc + 3) % 64;
        end
        drive(3'b000, 3'b000, '0, 1'b0, 6'd0);
        #1;
        chk("wrap_head_end", 32'(head), 32'd56);
        chk("wrap_ovf", 32'(overflow_err), 32'd0);

        // Randomized traffic with occasional valid recoveries.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clock);
            #1;
            dispatch_req = 3'($urandom);
            retire_en    = 3'($urandom);
            retire_reg   = 18'($urandom);
            recover_en   = ($urandom_range(15, 0) == 0);
            c            = $urandom_range(32, 0);
            recover_head = 6'((mt - c) % 64);
            if (cyc % 500 == 499) do_reset();
        end
        drive(3'b000, 3'b000, '0, 1'b0, 6'd0);
        @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freelist_mw.md
Name: freelist_mw

Overview:
- Parametrised physical-register free list for the rename stage. Successor to the fixed 3-way, 32-entry free list.
- Circular buffer of free physical register tags. Hands out up to WAYS tags per cycle to dispatch and accepts up to WAYS tags per cycle from retire.
- Restores its head pointer on branch mispredict recovery.
- Adds pointer wrap bits (no empty/full ambiguity), an explicit free count, and a sticky overflow error.

Parameters:
- PR_W, 6, width of a physical register tag
- DEPTH, 32, number of entries; power of two, at least 4
- WAYS, 3, dispatch and retire lanes per cycle; 1 to 4, must not exceed DEPTH
- FIRST_FREE, 32, tag held in entry 0 after reset; entry i holds FIRST_FREE+i

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- dispatch_req  in  WAYS  per-lane request for a free tag
- retire_en  in  WAYS  per-lane retire valid
- retire_reg  in  WAYS*PR_W  tag freed on each retire lane
- recover_en  in  1  branch recovery
- recover_head  in  log2(DEPTH)+1  head snapshot to restore, wrap bit included
- free_reg  out  WAYS*PR_W  tag granted on each lane; 0 when not granted
- free_valid  out  WAYS  per-lane grant
- head  out  log2(DEPTH)+1  current head with wrap bit, for checkpointing
- free_count  out  log2(DEPTH)+1  number of stored free tags
- overflow_err  out  1  sticky: a retire was dropped because the list was full

Behaviour:
- Pointers: head and tail are log2(DEPTH)+1 bits; the low bits index the array and the MSB is the wrap bit.
- free_count = tail - head, modulo 2^(log2(DEPTH)+1).
- Reset (asynchronous, reset_n low):
  - head=0, tail=DEPTH (wrap bit set, index 0), so free_count=DEPTH.
  - Array entry i = FIRST_FREE+i.
  - overflow_err=0.
  - Outputs free_valid=0 and free_reg=0 while reset_n is low.
- Grant (combinational, same cycle):
  - Requesting lanes are ranked in ascending lane order; the k-th requesting lane (k=0,1,...) receives array[head+k].
  - A lane is granted only if k < free_count, using the registered count; same-cycle retires do not feed grants unless FREELIST_BYPASS_EN is defined.
  - Lanes that are not granted output free_valid=0 and free_reg=0.
  - Dispatch stalls on partial grants; the free list does not hold requests across cycles.
- Grant commit: on the clock edge, head advances by the number of granted lanes.
- Retire:
  - Enabled lanes are compacted in ascending lane order and written to array[tail], array[tail+1], and so on.
  - tail advances by the number of accepted retires.
  - A retire is accepted only while (free_count - grants + accepted so far) < DEPTH.
  - Excess retires are dropped and set overflow_err, which stays set until reset.
- Wrap-around: all index arithmetic is modulo DEPTH; the wrap bit toggles on crossing DEPTH-1 to 0.
- Recovery (recover_en=1):
  - All grants are suppressed that cycle (free_valid=0).
  - At the edge, head <= recover_head.
  - Same-cycle retires are still accepted, using the capacity check against free_count computed from recover_head.
  - tail updates normally.
  - recover_head must lie between the current head and tail in wrap order; otherwise behaviour is undefined and no check is required.
- Simultaneous grant and retire in the same cycle:
  - Both pointers update independently.
  - free_count_next = free_count - grants + accepted retires.
- No internal FSM beyond the pointer state. Latency: grant is 0 cycles; a retired tag becomes grantable 1 cycle later.

Optional Feature:
- Macro FREELIST_BYPASS_EN.
- When defined: requesting lanes with k >= free_count are served from this cycle's retire lanes in ascending lane order. Each bypassed tag is consumed directly and not written to the array, so head and tail stay consistent (tail advances only by retires not bypassed). free_count_next counts a bypassed tag as neither added nor removed.
- When undefined: grants come only from stored entries, as described above.

Test Plan:
- Reset, then dispatch_req=3'b111 once -> free_reg lanes 0,1,2 = 32,33,34, free_valid=3'b111; next cycle head=3, free_count=29.
- Drain: request 3 per cycle for 11 cycles -> the 11th cycle grants only lanes 0,1 (free_count=2); afterwards free_count=0 and the next request gives free_valid=0.
- Empty list, retire_en=3'b101, retire_reg={40,x,41}, dispatch_req=3'b001 -> no grant that cycle; next cycle the grant is 41, free_count goes from 2 to 1.
- Full list (reset state), retire_en=3'b001 with no dispatch -> retire dropped, overflow_err=1 and stays 1 until reset_n is asserted low.
- Grant 5 tags (head=5), then recover_en=1 with recover_head=2 and dispatch_req=3'b111 -> free_valid=0; next cycle head=2, free_count=30, and the next grant returns the tag at array index 2 (34).
- Wrap: cycle 40 grants and retires of 3 per cycle -> the head wrap bit toggles at index 31 to 0; tags are returned in FIFO order; free_count is unchanged each cycle; overflow_err=0.
